sym_weight_eval: RTL and testbench

Parametrised, multi-cycle evaluator for totally symmetric Boolean functions of a WIDTH-bit word, the sequential successor of the fixed 8-input symmetric benchmark netlists. It accepts a data word plus a runtime weight mask, counts ones CHUNK bits per cycle, and returns `z = mask[popcount(x)]` together with the weight itself. It sits between a stimulus source and a result sink on valid/ready streams, so the same function family (rd-style, threshold, parity, exact-k) can be selected at run time without re-synthesis.

---
 rtl/sym_eval_pkg.sv | 22 ++
 rtl/chunk_popcount.sv | 22 ++
 rtl/sym_weight_eval.sv | 107 ++++++++++
 tb/tb_sym_weight_eval.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_eval_pkg.sv
// Shared types and helpers for the symmetric-function evaluator.
package sym_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to hold any count from 0 to width inclusive.
    function automatic int cw(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int popcnt(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Combinational ones-count of one CHUNK-bit slice.
module chunk_popcount
    import sym_eval_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0]         bits,
    output logic [cw(CHUNK)-1:0]     count
);

    localparam int PW = cw(CHUNK);

    // NOTE: combinational logic uses blocking '=' and assigns a default first,
    // so every path drives count and no latch is inferred.
    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + PW'(bits[i]);
        end
    end

endmodule

// File: rtl/sym_weight_eval.sv
// Multi-cycle evaluator of z = mask[popcount(data)], CHUNK bits counted per cycle,
// with valid/ready handshakes on both sides.
module sym_weight_eval
    import sym_eval_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [WIDTH:0]        in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_z,
    output logic [cw(WIDTH)-1:0]  out_weight
);

    localparam int CW    = cw(WIDTH);
    localparam int PW    = cw(CHUNK);
    localparam int BEATS = WIDTH / CHUNK;
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("sym_weight_eval: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    state_t            state;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH:0]    mask_q;
    logic [CW-1:0]     acc;
    logic [IW-1:0]     idx;

    logic [CHUNK-1:0]  chunk;
    logic [PW-1:0]     chunk_ones;
    logic [CW-1:0]     sum_next;
    logic              last_beat;

    assign chunk     = data_q[int'(idx)*CHUNK +: CHUNK];
    assign sum_next  = acc + CW'(chunk_ones);
    assign last_beat = (idx == IW'(BEATS - 1));

    // The only combinational input-to-output path: DONE frees the slot when the sink takes the result.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

    chunk_popcount #(.CHUNK(CHUNK)) u_chunk_popcount (
        .bits  (chunk),
        .count (chunk_ones)
    );

    // NOTE: the capture registers are small flops, not a memory, so they are reset
    // along with the state; sequential state is updated only with '<='.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            data_q     <= '0;
            mask_q     <= '0;
            acc        <= '0;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_z      <= 1'b0;
            out_weight <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        mask_q <= in_mask;
                        acc    <= '0;
                        idx    <= '0;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= sum_next;
                    idx <= idx + IW'(1);
                    if (last_beat) begin
                        out_weight <= sum_next;
                        out_z      <= mask_q[sum_next];
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            data_q <= in_data;
                            mask_q <= in_mask;
                            acc    <= '0;
                            idx    <= '0;
                            state  <= ACCUM;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sym_weight_eval.sv
// Self-checking bench for sym_weight_eval: directed table, handshake corner cases,
// parameter variants and a randomized popcount model comparison.
module tb_sym_weight_eval;
    import sym_eval_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic out_ready;

    // WIDTH=8, CHUNK=2
    logic       in_valid, in_ready, out_valid, out_z;
    logic [7:0] in_data;
    logic [8:0] in_mask;
    logic [3:0] out_weight;

    // WIDTH=8, CHUNK=8
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_z;
    logic [7:0] a_in_data;
    logic [8:0] a_in_mask;
    logic [3:0] a_out_weight;

    // WIDTH=16, CHUNK=4
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_z;
    logic [15:0] b_in_data;
    logic [16:0] b_in_mask;
    logic [4:0]  b_out_weight;

    sym_weight_eval #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_z(out_z), .out_weight(out_weight)
    );

    sym_weight_eval #(.WIDTH(8), .CHUNK(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_mask(a_in_mask), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_z(a_out_z), .out_weight(a_out_weight)
    );

    sym_weight_eval #(.WIDTH(16), .CHUNK(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_mask(b_in_mask), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_z(b_out_z), .out_weight(b_out_weight)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Submit one request to the 8/2 instance and wait (bounded) for its result.
    task automatic run_main(input logic [7:0] d, input logic [8:0] m,
                            output int lat, output logic [3:0] w, output logic z);
        int guard;
        guard    = 0;
        in_data  = d;
        in_mask  = m;
        in_valid = 1'b1;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        check("accept_wait", guard, 0);
        step();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_mask  = 9'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        w = out_weight;
        z = out_z;
    endtask

    task automatic run_b(input logic [15:0] d, input logic [16:0] m,
                         output int lat, output logic [4:0] w, output logic z);
        b_in_data  = d;
        b_in_mask  = m;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 20) begin
            step();
            lat++;
        end
        w = b_out_weight;
        z = b_out_z;
    endtask

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [8:0] mask;
        int         weight;
        logic       z;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[7];
        int         lat, seen, exp_w;
        logic [3:0] w;
        logic [4:0] wb;
        logic       z;
        logic [7:0] rd;
        logic [8:0] rm;
        logic [15:0] rbd;
        logic [16:0] rbm;
        int         hold;

        vecs[0] = '{"exact4_b2",   8'b1011_0010, 9'h010, 4, 1'b1};
        vecs[1] = '{"exact4_07",   8'h07,        9'h010, 3, 1'b0};
        vecs[2] = '{"all_ones",    8'hFF,        9'h100, 8, 1'b1};
        vecs[3] = '{"zero_w0",     8'h00,        9'h001, 0, 1'b1};
        vecs[4] = '{"zero_not0",   8'h00,        9'h1FE, 0, 1'b0};
        vecs[5] = '{"odd_par_0f",  8'h0F,        9'h0AA, 4, 1'b0};
        vecs[6] = '{"all_55",      8'h55,        9'h1FF, 4, 1'b1};

        rst_n = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_data = '0; in_mask = '0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_mask = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mask = '0;
        #12;
        check("rst_out_valid",  out_valid, 0);
        check("rst_in_ready",   in_ready, 1);
        check("rst_out_z",      out_z, 0);
        check("rst_out_weight", out_weight, 0);
        rst_n = 1'b1;

        // Directed table with the sink always ready.
        foreach (vecs[i]) begin
            run_main(vecs[i].data, vecs[i].mask, lat, w, z);
            check({vecs[i].name, "_latency"}, lat, 4);
            check({vecs[i].name, "_weight"}, w, vecs[i].weight);
            check({vecs[i].name, "_z"}, z, vecs[i].z);
            step();
        end

        // Backpressure, then a consume coinciding with a new accept.
        out_ready = 1'b0;
        run_main(8'b1011_0010, 9'h010, lat, w, z);
        check("bp_latency", lat, 4);
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_weight_hold", out_weight, 4);
            check("bp_z_hold", out_z, 1);
            step();
        end
        in_valid  = 1'b1;
        in_data   = 8'h0F;
        in_mask   = 9'h0AA;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready_passthru", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_data  = 8'hFF;
        check("b2b_consumed", out_valid, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("b2b_latency", lat, 4);
        check("b2b_weight", out_weight, 4);
        check("b2b_z", out_z, 0);
        step();

        // Asynchronous reset during the second accumulation beat.
        in_data = 8'hFF; in_mask = 9'h100; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        #10;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid) seen++;
        end
        check("midrst_no_stale", seen, 0);
        run_main(8'h3C, 9'h010, lat, w, z);
        check("post_rst_latency", lat, 4);
        check("post_rst_weight", w, 4);
        check("post_rst_z", z, 1);
        step();

        // CHUNK == WIDTH: single-cycle latency.
        a_in_data = 8'b1011_0010; a_in_mask = 9'h010; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("c8_latency", lat, 1);
        check("c8_weight", a_out_weight, 4);
        check("c8_z", a_out_z, 1);
        step();
        a_in_data = 8'hFF; a_in_mask = 9'h0FF; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("c8_ff_latency", lat, 1);
        check("c8_ff_weight", a_out_weight, 8);
        check("c8_ff_z", a_out_z, 0);
        step();

        // WIDTH=16, CHUNK=4.
        run_b(16'hF0F1, 17'h00200, lat, wb, z);
        check("w16_latency", lat, 4);
        check("w16_weight", wb, 9);
        check("w16_z", z, 1);
        step();
        for (int t = 0; t < 50; t++) begin
            rbd = 16'($urandom);
            rbm = 17'($urandom);
            exp_w = popcnt(64'(rbd));
            run_b(rbd, rbm, lat, wb, z);
            check("w16_rand_weight", wb, exp_w);
            check("w16_rand_z", z, rbm[exp_w]);
            step();
        end

        // Randomized words and masks with random sink stalls.
        out_ready = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            rd = 8'($urandom);
            rm = 9'($urandom);
            exp_w = popcnt(64'(rd));
            run_main(rd, rm, lat, w, z);
            check("rand_latency", lat, 4);
            check("rand_weight", w, exp_w);
            check("rand_z", z, rm[exp_w]);
            hold = int'($urandom_range(0, 2));
            for (int c = 0; c < hold; c++) begin
                step();
                check("rand_hold_weight", out_weight, exp_w);
            end
            out_ready = 1'b1;
            step();
            check("rand_consumed", out_valid, 0);
            out_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
